// File: rtl/cac_key_loader_pkg.sv
// Shared types and constants for the CAC key provisioning loader.
package cac_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ARMED,
    ST_LOCKOUT
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic int unsigned key_nbytes(input int unsigned key_w);
    return key_w / 8;
  endfunction

endpackage

// File: rtl/cac_key_loader_if.sv
// Byte-stream in / keyinput-bus out signal bundle of the key loader.
interface cac_key_loader_if #(
  parameter int unsigned KEY_W = 32
);
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             load_err;
  logic             locked_out;
  logic             busy;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, key_out, key_valid, load_err, locked_out, busy
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, key_out, key_valid, load_err, locked_out, busy
  );
endinterface

// File: rtl/cac_key_loader_crc8.sv
// Running CRC-8 (poly 0x07, MSB-first, no reflection, no final XOR), one byte per cycle.
module cac_crc8
  import cac_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q ^ byte_i;
    for (int i = 0; i < 8; i++) begin
      crc_d = crc_d[7] ? ((crc_d << 1) ^ CRC8_POLY) : (crc_d << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= CRC8_INIT;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cac_key_loader.sv
// Key loader: collects key bytes, verifies the CRC-8 trailer and only then drives
// the keyinput bus; repeated failures latch a lockout that only reset clears.
module cac_key_loader
  import cac_key_pkg::*;
#(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  cac_key_loader_if.slave    bus_io
);

  localparam int unsigned NBYTES = key_nbytes(KEY_W);
  localparam int unsigned BCW    = $clog2(NBYTES + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam int unsigned FW     = $clog2(MAX_FAIL + 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [7:0]       cmp_q, cmp_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             load_err_q, load_err_d;
  logic             locked_q, locked_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic             fail_c;
  logic             crc_clr_c;
  logic             crc_en_c;
  logic [FW-1:0]    fail_inc_c;
  logic [7:0]       crc_c;

  cac_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr_c),
    .en_i   (crc_en_c),
    .byte_i (bus_io.in_data),
    .crc_o  (crc_c)
  );

  assign accept_c   = bus_io.in_valid && in_ready_q;
  assign fail_inc_c = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    tmo_d       = tmo_q;
    fail_d      = fail_q;
    shadow_d    = shadow_q;
    cmp_d       = cmp_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    load_err_d  = 1'b0;
    locked_d    = locked_q;
    fail_c      = 1'b0;
    crc_clr_c   = 1'b0;
    crc_en_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (bus_io.start) begin
          state_d     = ST_LOAD;
          bcnt_d      = '0;
          tmo_d       = '0;
          shadow_d    = '0;
          crc_clr_c   = 1'b1;
          key_d       = '0;
          key_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          // tmo counts cycles since the last accepted byte, this one included
          tmo_d = TW'(1);
          if (bcnt_q < BCW'(NBYTES)) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
              if (bcnt_q == BCW'(b)) shadow_d[8*b +: 8] = bus_io.in_data;
            end
            crc_en_c = 1'b1;
            bcnt_d   = bcnt_q + BCW'(1);
          end else begin
            cmp_d   = bus_io.in_data;
            state_d = ST_CHECK;
          end
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          fail_c = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_CHECK: begin
        if (cmp_q == crc_c) begin
          key_d       = shadow_q;
          key_valid_d = 1'b1;
          fail_d      = '0;
          state_d     = ST_ARMED;
        end else begin
          fail_c = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail_c) begin
      load_err_d = 1'b1;
      fail_d     = fail_inc_c;
      if (fail_inc_c == FW'(MAX_FAIL)) begin
        state_d  = ST_LOCKOUT;
        locked_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bcnt_q      <= '0;
      tmo_q       <= '0;
      fail_q      <= '0;
      shadow_q    <= '0;
      cmp_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tmo_q       <= tmo_d;
      fail_q      <= fail_d;
      shadow_q    <= shadow_d;
      cmp_q       <= cmp_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
      locked_q    <= locked_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_io.in_ready   = in_ready_q;
  assign bus_io.key_out    = key_q;
  assign bus_io.key_valid  = key_valid_q;
  assign bus_io.load_err   = load_err_q;
  assign bus_io.locked_out = locked_q;
  assign bus_io.busy       = busy_q;

endmodule
